// File: rtl/uart_rx_frame.sv
// 16x-oversampled UART receiver: a 2-flop input synchroniser, then a start/data/stop state machine.
// It gives one done or error pulse per frame. Define UART_RX_PARITY_EN to add one even-parity bit.
module uart_rx_frame #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic            rx_done_tick,
    output logic            rx_err_tick,
    output logic [DBIT-1:0] dout,
    output logic            busy
);
    localparam int unsigned SW = (SB_TICK > 16) ? 5 : 4;
    localparam int unsigned NW = $clog2(DBIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            rx_meta_q, rxs_q;
    logic            par_ok;

`ifdef UART_RX_PARITY_EN
    logic            parity_q, parity_d;

    // Even parity over data plus parity bit must reduce to zero.
    assign par_ok = ~(^{b_q, parity_q});
`else
    assign par_ok = 1'b1;
`endif

    // Synchroniser resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            s_q      <= '0;
            n_q      <= '0;
            b_q      <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            n_q      <= n_d;
            b_q      <= b_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
`ifdef UART_RX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        b_d      = b_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rxs_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rxs_q, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        parity_d = rxs_q;
                        s_d      = '0;
                        state_d  = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        dout_d  = b_q;
                        state_d = IDLE;
                        if (rxs_q && par_ok) begin
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d       = (state_d != IDLE);
    assign rx_done_tick = done_q;
    assign rx_err_tick  = err_q;
    assign dout         = dout_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: each frame pushes an expected {done, err, dout} entry,
// and a monitor records every pulse the receiver produces.
module tb_uart_rx_frame;
    localparam int unsigned CLK_PER_TICK = 4;
    localparam int unsigned BIT_CLKS     = 16 * CLK_PER_TICK;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx     = 1'b1;
    logic       rx_done_tick;
    logic       rx_err_tick;
    logic [7:0] dout;
    logic       busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned cyc      = 0;
    logic [9:0]  exp_q[$];
    logic [9:0]  obs_q[$];
    int unsigned obs_cyc[$];
    logic        both_high = 1'b0;

    uart_rx_frame #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_done_tick (rx_done_tick),
        .rx_err_tick  (rx_err_tick),
        .dout         (dout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin : tick_gen
        forever begin
            repeat (CLK_PER_TICK - 1) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    // Record every output pulse with its cycle stamp.
    always @(negedge clk) begin
        cyc <= cyc + 32'd1;
        if (rx_done_tick && rx_err_tick) both_high <= 1'b1;
        if (rx_done_tick || rx_err_tick) begin
            obs_q.push_back({rx_done_tick, rx_err_tick, dout});
            obs_cyc.push_back(cyc);
        end
    end

    task automatic idle_ticks(input int unsigned t);
        rx = 1'b1;
        repeat (t * CLK_PER_TICK) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad);
        logic good;
        good = stop && !par_bad;
        exp_q.push_back({good, !good, d});
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_bad);
`endif
        if (stop) begin
            send_bit(1'b1);
        end else begin
            rx = 1'b0;
            repeat (10 * CLK_PER_TICK) @(negedge clk);
            rx = 1'b1;
            repeat (6 * CLK_PER_TICK) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({rx_done_tick, rx_err_tick, busy} !== 3'b000)
            $display("FAIL reset_flags: got done/err/busy=%b, expected 000", {rx_done_tick, rx_err_tick, busy});
        else n_pass++;
        n_checks++;
        if (dout !== 8'h00) $display("FAIL reset_dout: got %h, expected 00", dout);
        else n_pass++;
        reset = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b, expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_good_frame();
        logic [9:0] ev, ex;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle_ticks(16);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL a5_busy: got %b, expected 0", busy);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL a5_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev = obs_q.pop_front();
            ex = exp_q.pop_front();
            n_checks++;
            if (ev !== ex)
                $display("FAIL a5_event: got done=%b err=%b dout=%h, expected done=%b err=%b dout=%h",
                         ev[9], ev[8], ev[7:0], ex[9], ex[8], ex[7:0]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (4 * CLK_PER_TICK) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL glitch_start: got busy=%b, expected 1", busy);
        else n_pass++;
        idle_ticks(24);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL glitch_abort: got busy=%b, expected 0", busy);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL glitch_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        obs_q.delete(); exp_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_framing_error();
        logic [9:0] ev, ex;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle_ticks(16);
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL ferr_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev = obs_q.pop_front();
            ex = exp_q.pop_front();
            n_checks++;
            if (ev !== ex)
                $display("FAIL ferr_event: got done=%b err=%b dout=%h, expected done=%b err=%b dout=%h",
                         ev[9], ev[8], ev[7:0], ex[9], ex[8], ex[7:0]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_back_to_back();
        logic [9:0]  ev, ex;
        int unsigned gap;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle_ticks(16);
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL b2b_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        if (obs_cyc.size() >= 2) begin
            gap = obs_cyc[1] - obs_cyc[0];
            n_checks++;
            if (gap !== FRAME_BITS * BIT_CLKS)
                $display("FAIL b2b_spacing: got %0d clk, expected %0d clk", gap, FRAME_BITS * BIT_CLKS);
            else n_pass++;
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev = obs_q.pop_front();
            ex = exp_q.pop_front();
            n_checks++;
            if (ev !== ex)
                $display("FAIL b2b_event: got done=%b err=%b dout=%h, expected done=%b err=%b dout=%h",
                         ev[9], ev[8], ev[7:0], ex[9], ex[8], ex[7:0]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] ev, ex;
        logic [7:0] d;
        d = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        rx = d[3];
        repeat (BIT_CLKS / 2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b, expected 1", busy);
        else n_pass++;
        reset = 1'b0;
        rx    = 1'b1;
        #1;
        n_checks++;
        if ({rx_done_tick, rx_err_tick, busy} !== 3'b000)
            $display("FAIL midrst_flags: got done/err/busy=%b, expected 000", {rx_done_tick, rx_err_tick, busy});
        else n_pass++;
        n_checks++;
        if (dout !== 8'h00) $display("FAIL midrst_dout: got %h, expected 00", dout);
        else n_pass++;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        idle_ticks(32);
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL midrst_no_pulse: got %0d events, expected 0", obs_q.size());
        else n_pass++;
        obs_q.delete(); obs_cyc.delete();
        send_frame(8'h81, 1'b1, 1'b0);
        idle_ticks(16);
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL after_rst_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev = obs_q.pop_front();
            ex = exp_q.pop_front();
            n_checks++;
            if (ev !== ex)
                $display("FAIL after_rst_event: got done=%b err=%b dout=%h, expected done=%b err=%b dout=%h",
                         ev[9], ev[8], ev[7:0], ex[9], ex[8], ex[7:0]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete(); obs_cyc.delete();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [9:0] ev, ex;
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        idle_ticks(16);
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL parity_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev = obs_q.pop_front();
            ex = exp_q.pop_front();
            n_checks++;
            if (ev !== ex)
                $display("FAIL parity_event: got done=%b err=%b dout=%h, expected done=%b err=%b dout=%h",
                         ev[9], ev[8], ev[7:0], ex[9], ex[8], ex[7:0]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete(); obs_cyc.delete();
    endtask
`endif

    task automatic test_exclusive();
        n_checks++;
        if (both_high !== 1'b0) $display("FAIL done_err_overlap: got %b, expected 0", both_high);
        else n_pass++;
    endtask

    initial begin : main
        test_reset();
        test_good_frame();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
